// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage load/store path:
// access-size codes and the access FSM states.
package mips_mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/load_align.sv
// Big-endian lane select and sign/zero extension of
// a 32-bit memory word for byte, half and word loads.
module load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        isSigned,
  output logic [31:0] result
);

  logic [7:0]  laneB;
  logic [15:0] laneH;

  always_comb begin
    laneB = rdata[31:24];
    unique case (offset)
      2'd0: laneB = rdata[31:24];
      2'd1: laneB = rdata[23:16];
      2'd2: laneB = rdata[15:8];
      2'd3: laneB = rdata[7:0];
      default: laneB = rdata[31:24];
    endcase
    laneH = offset[1] ? rdata[15:0] : rdata[31:16];
    result = rdata;
    if (size == SIZE_B)
      result = {{24{isSigned & laneB[7]}}, laneB};
    else if (size == SIZE_H)
      result = {{16{isSigned & laneH[15]}}, laneH};
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: req/ack data bus, stall, aligned load data.
// Optional misaligned-access trap: define MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [1:0]            MemSize,
  input  logic                  MemSigned,
  input  logic [31:0]           ALUResult,
  input  logic [31:0]           StoreData,
  output logic [31:0]           MemoryData,
  output logic                  Stall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [31:0]           dmem_wdata,
  input  logic [31:0]           dmem_rdata,
  input  logic                  dmem_ack
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  ,
  output logic                  misalign
`endif
);

  state_t state;
  state_t stateNext;

  logic        access;
  logic        isB;
  logic        isH;
  logic        trap;
  logic [1:0]  off;
  logic [3:0]  beNext;
  logic [31:0] wdataNext;
  logic [1:0]  offR;
  logic [1:0]  sizeR;
  logic        signedR;
  logic [31:0] aligned;

  assign access = MemRead | MemWrite;
  assign off    = ALUResult[1:0];
  assign isB    = (MemSize == SIZE_B);
  assign isH    = (MemSize == SIZE_H);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign trap = (isH & off[0]) | (!isB & !isH & (|off));
`else
  assign trap = 1'b0;
`endif

  // Big-endian: offset 0 is the top byte lane.
  always_comb begin
    beNext    = 4'b1111;
    wdataNext = StoreData;
    unique case (1'b1)
      isB: begin
        beNext    = 4'b1000 >> off;
        wdataNext = {4{StoreData[7:0]}};
      end
      isH: begin
        beNext    = off[1] ? 4'b0011 : 4'b1100;
        wdataNext = {2{StoreData[15:0]}};
      end
      default: ;
    endcase
  end

  load_align uAlign (
    .rdata    (dmem_rdata),
    .offset   (offR),
    .size     (sizeR),
    .isSigned (signedR),
    .result   (aligned)
  );

  always_ff @(negedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    Stall     = 1'b0;
    unique case (state)
      IDLE: begin
        Stall = access;
        if (access) stateNext = trap ? DONE : BUSY;
      end
      BUSY: begin
        Stall = 1'b1;
        if (dmem_ack) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      MemoryData <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      offR       <= '0;
      sizeR      <= SIZE_W;
      signedR    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (access) begin
          dmem_req   <= !trap;
          dmem_we    <= MemWrite;
          dmem_addr  <= {ALUResult[ADDR_WIDTH-1:2], 2'b00};
          dmem_be    <= beNext;
          dmem_wdata <= wdataNext;
          offR       <= off;
          sizeR      <= MemSize;
          signedR    <= MemSigned;
          if (trap) MemoryData <= '0;
        end
        BUSY: if (dmem_ack) begin
          dmem_req <= 1'b0;
          if (!dmem_we) MemoryData <= aligned;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  // High exactly during the DONE cycle that follows a trapped access.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) misalign <= 1'b0;
    else     misalign <= (state == IDLE) & access & trap;
  end
`endif

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store unit of the 5-stage MIPS pipeline, sitting between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns EX/MEM control (MemRead/MemWrite, size, signedness, address, store data) into a req/ack transaction on the data-memory bus. It stalls the pipeline until the access completes and presents aligned, sign/zero-extended load data as MemoryData to MEM/WB.

## Interface
- ADDR_WIDTH, 32, data-memory address width (≤32); dmem_addr = ALUResult[ADDR_WIDTH-1:0] with low 2 bits cleared
- clk  in  1  pipeline clock; all state updates on falling edge, like the pipeline registers
- rst  in  1  reset, asynchronous, active-high
- MemRead  in  1  load in MEM stage
- MemWrite  in  1  store in MEM stage; if both MemRead and MemWrite are high, MemWrite wins
- MemSize  in  2  00 byte, 01 half, 10 word, 11 treated as word
- MemSigned  in  1  1 = sign-extend loads (LB/LH), 0 = zero-extend (LBU/LHU)
- ALUResult  in  32  effective byte address
- StoreData  in  32  rt value for stores
- MemoryData  out  32  aligned/extended load result, to MEM/WB
- Stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble nothing
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_WIDTH  word-aligned address
- dmem_be  out  4  byte enables, bit 3 = bits 31:24
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  read data, valid with dmem_ack
- dmem_ack  in  1  one-cycle completion strobe

## Operation
- Big-endian lanes: byte offset k = ALUResult[1:0] maps to rdata[31-8k:24-8k], be bit 3-k. Half offset 0 maps to [31:16], be 1100; offset 2 maps to [15:0], be 0011. Word: be 1111.
- Store data: byte → {4{StoreData[7:0]}}, half → {2{StoreData[15:0]}}, word unchanged.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: access = MemRead|MemWrite. When access is high, latch address/size/signed/we/wdata/be and go to BUSY.
  - BUSY: dmem_req=1, with all bus outputs held from the latched copies. On dmem_ack, latch MemoryData (loads only; stores leave it unchanged) and go to DONE.
  - DONE: one cycle, then unconditionally IDLE. The pipeline advances at the end of DONE, so the same instruction is never reissued.
- Stall = (IDLE & access) | BUSY; combinational; low in DONE.
- dmem_req is registered (0 in IDLE/DONE). dmem_ack outside BUSY is ignored.
- Reset values: MemoryData=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, state IDLE. Stall then follows inputs combinationally.

## Timing
- Minimum load/store latency is 3 cycles in MEM: IDLE → BUSY(ack same cycle) → DONE. Each extra wait cycle on ack adds one.
- MemoryData is valid from the DONE edge and held until the next load completes. MEM/WB samples it at the end of DONE.
- rst mid-BUSY: request dropped immediately (async), state IDLE. Bus must tolerate an abandoned request.
- Ack in the same cycle dmem_req first rises is legal.

## Configuration
- MEM_ACCESS_MISALIGN_TRAP_EN defined: a half access with ALUResult[0]=1, or a word access with ALUResult[1:0]≠0, issues no bus transaction. IDLE goes straight to DONE and asserts output misalign (1 bit, registered, high only in DONE). MemoryData is forced to 0.
- Not defined: no misalign port. Low address bits below access size are ignored: half uses bit 1 only, word uses the aligned word.

## Structure
- Shared package mips_mem_pkg holds the MemSize encodings (SIZE_B/SIZE_H/SIZE_W) and the FSM state encoding.
- Sub-module load_align (combinational) takes rdata, offset, size and signed, and returns the 32-bit extended result. It is reused by the verification scoreboard.

## Test plan
- Word load, addr 0x100, rdata 0xDEADBEEF, ack after 2 waits → Stall high 4 cycles, MemoryData=0xDEADBEEF, dmem_be=1111.
- LB signed, addr 0x103, rdata 0x000000F0 → MemoryData=0xFFFFFFF0. LBU with the same address → 0x000000F0.
- SH, addr 0x202, StoreData 0x1234ABCD → dmem_we=1, be=0011, wdata=0xABCDABCD, addr 0x200. MemoryData unchanged.
- rst pulse while BUSY → dmem_req=0 immediately, MemoryData=0, IDLE. After release, the still-present load reissues.
- Ack pulse while IDLE with no access → ignored, no state change, Stall=0.
- With MEM_ACCESS_MISALIGN_TRAP_EN: LW addr 0x101 → no dmem_req, misalign=1 for one cycle, MemoryData=0, Stall high one cycle.
